uart_piso: RTL
==============

Name: uart_piso

Overview:
- UART transmitter: accepts an 8-bit byte via a send/busy handshake and serializes one 11-bit frame.
- Frame order: start(0), D0..D7 LSB first, parity, stop(1).
- Runs on the same oversampling clock as the receive path; each bit is held for i_prescale clocks, so the receiver's centre-sampling lines up.
- Sits between the host-side byte source and the TX pad, mirroring the receive SIPO.

Parameters:
- DATA_WIDTH, 8, payload bits per frame; frame length = DATA_WIDTH+3.

Ports:
- i_clk  input  1  oversampling clock (bit period = i_prescale cycles)
- i_arst_n  input  1  asynchronous active-low reset
- i_send  input  1  request to transmit i_data; accepted only when o_busy=0
- i_data  input  DATA_WIDTH  byte to send; latched on acceptance
- i_parity_type  input  2  01=odd, 10=even, 00/11=no parity (parity slot driven 1)
- i_prescale  input  6  clocks per bit: 8, 16 or 32; any other value treated as 8
- o_tx_out  output  1  serial line, idle high
- o_busy  output  1  high from the cycle after acceptance through the last stop-bit cycle
- o_done  output  1  one-cycle pulse on the final clock of the stop bit

Behaviour:
- Clock and reset: one clock (i_clk); reset is asynchronous and active-low (i_arst_n).
- Reset values: o_tx_out=1, o_busy=0, o_done=0, state=IDLE, counters=0. Assertion mid-frame forces the line high immediately and abandons the frame. No partial-frame recovery.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - o_tx_out=1.
  - If i_send=1 at a clock edge: latch i_data, i_parity_type and the decoded prescale into shadow registers, then go to START.
  - Changes to inputs after acceptance have no effect on the current frame.
- START: o_tx_out=0 for exactly P clocks (P = latched bit period), then DATA.
- DATA:
  - Drive shift_reg[0]; after P clocks shift right and increment bit_count.
  - After DATA_WIDTH bits go to PARITY.
- PARITY: drive for P clocks, then STOP.
  - Even: XOR of the 8 data bits.
  - Odd: inverse of that XOR.
  - None: 1.
- STOP: o_tx_out=1 for P clocks; o_done=1 on the last of them; then IDLE.
- Latency and throughput:
  - Start bit appears on the clock edge after acceptance.
  - Frame occupies 11*P clocks; o_done is in cycle 11*P counting the first start-bit cycle as 1.
  - Minimum one IDLE cycle (line high) between frames: i_send held high gives back-to-back frames with period 11*P+1.
- Bit counter: bit_timer counts 0..P-1 and wraps to 0 at each bit boundary. Width 6 bits, no overflow possible.
- i_send while o_busy=1: ignored, no queueing.
- Invalid prescale (e.g. 20): decoded to 8 at acceptance time.

Optional Feature:
- Macro: UART_PISO_TWO_STOP_EN.
- Defined: STOP lasts 2*P clocks, frame = 12*P, o_done on the last clock of the second stop bit.
- Undefined: a single stop bit as above.
- The receiver tolerates the extra idle-high period either way.

Decomposition:
- Shared package uart_pkg:
  - prescale constants (SAMPL8=8, SAMPL16=16, SAMPL32=32)
  - parity_t enum (PAR_NONE, PAR_ODD, PAR_EVEN)
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP)
  - FRAME_BITS constant (11)
- One sub-module: uart_bit_timer (loadable period, count enable, one-cycle bit_end pulse at P-1).
  - uart_piso instantiates it; the bit_end pulse drives the FSM transitions.

Test Plan:
- Reset: hold i_arst_n=0 with i_send=1 -> o_tx_out=1, o_busy=0, o_done=0. Release -> frame starts on the next edge.
- Even parity: prescale=16, i_data=8'hA5, parity=10 -> line sequence 0,1,0,1,0,0,1,0,1,0,1, each 16 clocks; o_done in cycle 176.
- Odd parity: prescale=8, i_data=8'h00, parity=01 -> start 0, eight 0s, parity 1, stop 1, each 8 clocks; frame 88 clocks.
- Handshake: pulse i_send with 8'h3C; mid-frame pulse i_send with 8'hFF -> second request ignored, only 8'h3C sent. Continuous i_send -> one idle-high cycle between frames.
- Boundary: prescale=6'd20 -> bits held 8 clocks. Assert reset at cycle 50 of a prescale=32 frame -> o_tx_out=1 asynchronously, o_busy=0, no o_done.
- With UART_PISO_TWO_STOP_EN: prescale=16, 8'hA5 -> stop high for 32 clocks; o_done in cycle 192.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, parity and TX state types.
// Prescale decode helper used by the transmit path.
package uart_pkg;

  localparam logic [5:0] SAMPL8  = 6'd8;
  localparam logic [5:0] SAMPL16 = 6'd16;
  localparam logic [5:0] SAMPL32 = 6'd32;

  localparam int FRAME_BITS = 11;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic logic [5:0] decode_prescale(
    input logic [5:0] p
  );
    case (p)
      SAMPL8, SAMPL16, SAMPL32: return p;
      default:                  return SAMPL8;
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts 0..period-1 while enabled.
// Pulses bit_end on the last clock of each bit.
module uart_bit_timer (
  input  logic       i_clk,
  input  logic       i_arst_n,
  input  logic       i_en,
  input  logic [5:0] i_period,
  output logic       o_bit_end
);

  logic [5:0] count;

  assign o_bit_end = i_en && (count == i_period - 6'd1);

  // Free-run within a bit, wrap at the boundary, hold 0 when idle.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n)
      count <= '0;
    else if (!i_en || o_bit_end)
      count <= '0;
    else
      count <= count + 6'd1;
  end

endmodule

// File: rtl/uart_piso.sv
// uart_piso: UART transmitter, start/8 data/parity/stop frame.
// Define UART_PISO_TWO_STOP_EN for two stop bits.
module uart_piso
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_send,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [1:0]            i_parity_type,
  input  logic [5:0]            i_prescale,
  output logic                  o_tx_out,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
`ifdef UART_PISO_TWO_STOP_EN
  localparam logic [CW-1:0] STOP_LAST = CW'(1);
`else
  localparam logic [CW-1:0] STOP_LAST = CW'(0);
`endif

  tx_state_t             state;
  tx_state_t             state_nxt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CW-1:0]         bit_count;
  logic [5:0]            period;
  logic                  par_bit;
  logic                  bit_end;
  logic                  accept;

  assign accept = (state == IDLE) && i_send;

  uart_bit_timer u_timer (
    .i_clk     (i_clk),
    .i_arst_n  (i_arst_n),
    .i_en      (state != IDLE),
    .i_period  (period),
    .o_bit_end (bit_end)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next state and line/handshake outputs.
  always_comb begin
    state_nxt = state;
    o_tx_out  = 1'b1;
    o_busy    = 1'b1;
    o_done    = 1'b0;
    unique case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_send)
          state_nxt = START;
      end
      START: begin
        o_tx_out = 1'b0;
        if (bit_end)
          state_nxt = DATA;
      end
      DATA: begin
        o_tx_out = shift_reg[0];
        if (bit_end && bit_count == DATA_LAST)
          state_nxt = PARITY;
      end
      PARITY: begin
        o_tx_out = par_bit;
        if (bit_end)
          state_nxt = STOP;
      end
      STOP: begin
        if (bit_end && bit_count == STOP_LAST) begin
          o_done    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shadow registers: captured at acceptance, shifted per data bit.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      shift_reg <= '0;
      bit_count <= '0;
      period    <= SAMPL8;
      par_bit   <= 1'b1;
    end else if (accept) begin
      shift_reg <= i_data;
      bit_count <= '0;
      period    <= decode_prescale(i_prescale);
      if (i_parity_type == PAR_EVEN)
        par_bit <= ^i_data;
      else if (i_parity_type == PAR_ODD)
        par_bit <= ~^i_data;
      else
        par_bit <= 1'b1;
    end else if (bit_end) begin
      case (state)
        DATA: begin
          shift_reg <= shift_reg >> 1;
          bit_count <= (bit_count == DATA_LAST) ?
                       '0 : bit_count + CW'(1);
        end
        STOP:    bit_count <= bit_count + CW'(1);
        default: ;
      endcase
    end
  end

endmodule
